// File: rtl/conv_pkg.sv
// Shared defaults, latency and coefficient address layout for the 3x3 conv lanes.
package conv_pkg;
   localparam int WI_DEF      = 8;
   localparam int BW_DEF      = 32;
   localparam int ACCW_DEF    = 32;
   localparam int CONV_LAT    = 3;
   localparam int KW          = 9;
   localparam int BIAS_OFS    = 9;
   localparam int COEF_STRIDE = 10;
endpackage

// File: rtl/conv3x3_mac.sv
// One conv lane: operand capture, 9 products with row sums, final sum plus bias.
// Optional CONV_RELU_EN clamps the final sum at zero.
module conv3x3_mac
   import conv_pkg::*;
#(
   parameter int WI   = WI_DEF,
   parameter int BW   = BW_DEF,
   parameter int ACCW = ACCW_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ld1,
   input  logic               ld2,
   input  logic               ld3,
   input  logic [KW*WI-1:0]   win,
   input  logic [KW*WI-1:0]   wgt,
   input  logic [BW-1:0]      bias,
   output logic [ACCW-1:0]    sum
);
   logic [WI-1:0]          a1 [KW];
   logic [WI-1:0]          w1 [KW];
   logic [BW-1:0]          b1;
   logic signed [2*WI-1:0] prod [KW];
   logic [ACCW-1:0]        row [3];
   logic [ACCW-1:0]        r2 [3];
   logic [ACCW-1:0]        b2;
   logic [ACCW-1:0]        total;

   // Window packs row 1 and x0 in the MSBs; weights are row-major from bit 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < KW; k++) begin
            a1[k] <= '0;
            w1[k] <= '0;
         end
         b1 <= '0;
      end else if (ld1) begin
         for (int k = 0; k < KW; k++) begin
            a1[k] <= win[(KW-1-k)*WI +: WI];
            w1[k] <= wgt[k*WI +: WI];
         end
         b1 <= bias;
      end
   end

   always_comb begin
      for (int k = 0; k < KW; k++)
         prod[k] = (2*WI)'(signed'(a1[k])) * (2*WI)'(signed'(w1[k]));
      for (int ky = 0; ky < 3; ky++) begin
         row[ky] = '0;
         for (int kx = 0; kx < 3; kx++)
            row[ky] = row[ky] + ACCW'(prod[ky*3+kx]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int ky = 0; ky < 3; ky++)
            r2[ky] <= '0;
         b2 <= '0;
      end else if (ld2) begin
         for (int ky = 0; ky < 3; ky++)
            r2[ky] <= row[ky];
         b2 <= ACCW'(signed'(b1));
      end
   end

   assign total = r2[0] + r2[1] + r2[2] + b2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         sum <= '0;
      else if (ld3) begin
`ifdef CONV_RELU_EN
         sum <= total[ACCW-1] ? '0 : total;
`else
         sum <= total;
`endif
      end
   end
endmodule

// File: rtl/conv3x3_lane_array.sv
// LANES parallel 3x3 conv lanes over NOC channels in phases; coefficient RAM,
// phase counter and stall handshake. Optional macro: CONV_RELU_EN.
module conv3x3_lane_array
   import conv_pkg::*;
#(
   parameter int WI    = WI_DEF,
   parameter int BW    = BW_DEF,
   parameter int ACCW  = ACCW_DEF,
   parameter int LANES = 4,
   parameter int NOC   = 16,
   localparam int NGRP = NOC / LANES,
   localparam int AW   = $clog2(NOC*COEF_STRIDE),
   localparam int OW   = $clog2(NOC) + 1,
   localparam int PW   = $clog2(NGRP) + 1
) (
   input  logic                  iClk,
   input  logic                  iRst,
   input  logic                  iInValid,
   output logic                  oInReady,
   input  logic [3*WI-1:0]       iWindowInRow1,
   input  logic [3*WI-1:0]       iWindowInRow2,
   input  logic [3*WI-1:0]       iWindowInRow3,
   input  logic                  iMapDone,
   input  logic                  iWgtWe,
   input  logic [AW-1:0]         iWgtAddr,
   input  logic [BW-1:0]         iWgtData,
   output logic                  oValid,
   input  logic                  iOutReady,
   output logic [LANES*ACCW-1:0] oData,
   output logic [OW-1:0]         oOcBase,
   output logic [PW-1:0]         oPhase,
   output logic                  oAllDone
);
   logic [WI-1:0]    wmem [NOC][KW];
   logic [BW-1:0]    bmem [NOC];
   logic [PW-1:0]    phase;
   logic [PW-1:0]    tag1, tag2, tag3;
   logic             v1, v2, v3;
   logic             all_done;
   logic             en;
   logic             accept;
   logic             last;
   logic [KW*WI-1:0] win;

   assign en       = !(v3 && !iOutReady);
   assign oInReady = !iRst && en;
   assign accept   = iInValid && oInReady;
   assign last     = phase == PW'(NGRP-1);
   assign win      = {iWindowInRow1, iWindowInRow2, iWindowInRow3};

   // Addresses past the last channel match no entry and are dropped.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         for (int oc = 0; oc < NOC; oc++) begin
            bmem[oc] <= '0;
            for (int k = 0; k < KW; k++)
               wmem[oc][k] <= '0;
         end
      end else if (iWgtWe) begin
         for (int oc = 0; oc < NOC; oc++) begin
            for (int k = 0; k < KW; k++)
               if (iWgtAddr == AW'(oc*COEF_STRIDE + k))
                  wmem[oc][k] <= iWgtData[WI-1:0];
            if (iWgtAddr == AW'(oc*COEF_STRIDE + BIAS_OFS))
               bmem[oc] <= iWgtData;
         end
      end
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         phase    <= '0;
         all_done <= 1'b0;
      end else begin
         all_done <= iMapDone && last;
         if (iMapDone)
            phase <= last ? '0 : phase + PW'(1);
      end
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         v1   <= 1'b0;
         v2   <= 1'b0;
         v3   <= 1'b0;
         tag1 <= '0;
         tag2 <= '0;
         tag3 <= '0;
      end else if (en) begin
         v1 <= accept;
         v2 <= v1;
         v3 <= v2;
         if (accept) tag1 <= phase;
         if (v1)     tag2 <= tag1;
         if (v2)     tag3 <= tag2;
      end
   end

   assign oValid   = v3;
   assign oOcBase  = OW'(tag3) * OW'(LANES);
   assign oPhase   = phase;
   assign oAllDone = all_done;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [KW*WI-1:0] wgt;
      logic [BW-1:0]    bia;

      always_comb begin
         wgt = '0;
         bia = '0;
         for (int g = 0; g < NGRP; g++) begin
            if (phase == PW'(g)) begin
               for (int k = 0; k < KW; k++)
                  wgt[k*WI +: WI] = wmem[g*LANES+l][k];
               bia = bmem[g*LANES+l];
            end
         end
      end

      conv3x3_mac #(
         .WI   (WI),
         .BW   (BW),
         .ACCW (ACCW)
      ) u_mac (
         .clk  (iClk),
         .rst  (iRst),
         .ld1  (accept),
         .ld2  (en && v1),
         .ld3  (en && v2),
         .win  (win),
         .wgt  (wgt),
         .bias (bia),
         .sum  (oData[l*ACCW +: ACCW])
      );
   end
endmodule

// File: doc/conv3x3_lane_array.md
CONV3X3_LANE_ARRAY -- requirements
Module: conv3x3_lane_array

Interface
REQ-001 Parameter WI, default 8: signed pixel and weight width.
REQ-002 Parameter BW, default 32: signed bias width.
REQ-003 Parameter ACCW, default 32: signed accumulator and output width.
REQ-004 Parameter LANES, default 4: parallel output channels per phase.
REQ-005 Parameter NOC, default 16: total output channels; SHALL be a multiple of LANES; NGRP = NOC/LANES.
REQ-006 iClk  in  1  clock; all state on rising edge.
REQ-007 iRst  in  1  reset, asynchronous, active-high.
REQ-008 iInValid  in  1  window valid.
REQ-009 oInReady  out  1  window accepted when iInValid && oInReady.
REQ-010 iWindowInRow1/2/3  in  3*WI  window rows, packed {x0,x1,x2}, x0 in the MSBs.
REQ-011 iMapDone  in  1  one-cycle pulse: current feature map finished.
REQ-012 iWgtWe  in  1  coefficient write strobe.
REQ-013 iWgtAddr  in  $clog2(NOC*10)  coefficient address: oc*10+k; k=0..8 weight (row-major), k=9 bias.
REQ-014 iWgtData  in  BW  write data; weights use the low WI bits.
REQ-015 oValid  out  1  all lanes valid.
REQ-016 iOutReady  in  1  downstream accepts when oValid && iOutReady.
REQ-017 oData  out  LANES*ACCW  lane L at bits [L*ACCW +: ACCW].
REQ-018 oOcBase  out  $clog2(NOC)+1  output channel of lane 0 (phase*LANES).
REQ-019 oPhase  out  $clog2(NGRP)+1  current phase.
REQ-020 oAllDone  out  1  one-cycle pulse when the last phase's map completes.

Function
REQ-021 Lane L in phase p SHALL compute sum(a[ky][kx]*w[p*LANES+L][ky][kx]) + bias[p*LANES+L], signed, modulo 2^ACCW (wrap, no saturation).
REQ-022 The pipeline SHALL be 3 stages: operand/coefficient capture with phase tag, 9 products plus partial tree, final sum plus bias into the output register.
REQ-023 With no stall, a window accepted at edge k SHALL appear on oData with oValid high after edge k+3.
REQ-024 Stall: when oValid && !iOutReady, every stage SHALL hold; oInReady = !(oValid && !iOutReady).
REQ-025 oData and oOcBase SHALL stay stable while oValid && !iOutReady.
REQ-026 The phase tag SHALL travel with each window; oOcBase reflects the tag of the emitted data, not the current phase.
REQ-027 Phase SHALL advance on every iMapDone pulse; from NGRP-1 it SHALL wrap to 0, and oAllDone pulses on the following cycle.
REQ-028 iMapDone in the same cycle as an accepted window: the window uses the old phase and the phase advances afterward.
REQ-029 A coefficient write SHALL take effect for windows accepted on the cycle after the write edge; in-flight windows are unaffected.
REQ-030 Writes to addresses >= NOC*10 SHALL be ignored.
REQ-031 A window not accepted (iInValid low or oInReady low) SHALL produce no output.

Reset
REQ-032 On iRst, asynchronously: oValid=0, oData=0, oOcBase=0, oPhase=0, oAllDone=0, all pipeline valids=0, all coefficients=0.
REQ-033 While iRst is high, oInReady=0; after release it becomes 1 with no extra delay.
REQ-034 Reset mid-stream SHALL discard all in-flight windows; no partial output follows release.

Configuration
REQ-035 Macro CONV_RELU_EN: when defined, each lane's output SHALL be max(sum,0) at the final stage with unchanged latency; when undefined, the raw signed sum is output.

Structure
REQ-036 Shared package conv_pkg SHALL hold the WI/BW/ACCW defaults, the latency constant CONV_LAT=3, and the coefficient address offsets (KW=9, BIAS_OFS=9, COEF_STRIDE=10).
REQ-037 Sub-module conv3x3_mac (one lane: 9 products, adder tree, bias, stall-enabled registers) SHALL be instantiated LANES times via generate; the top holds the coefficient RAM, the phase counter and the handshake.

Verification
REQ-038 All weights 1, bias 0, window all 2 -> every lane outputs 18 at edge k+3, oOcBase=0.
REQ-039 Weights oc n = n (all 9), bias oc n = -n, window all 1, phases 0..3 via iMapDone -> lane L in phase p outputs 8*(4p+L); oAllDone pulses once after the 4th iMapDone.
REQ-040 Stream 10 windows with iOutReady low on cycles 5-8 -> no loss or duplication, order preserved, oData held during the stall.
REQ-041 CONV_RELU_EN defined, weights -1, bias 0, window all 5 -> output 0; undefined -> -45.
REQ-042 Window accepted together with iMapDone in phase 0 -> output tagged oOcBase=0; next window tagged oOcBase=LANES.
REQ-043 iRst asserted with 3 windows in flight -> oValid=0 immediately, no output after release, coefficients read back as 0 (output = 0).
